// File: rtl/naive_pkg.sv
// Shared opcodes, funct3 codes, ALU/state enums and the load lane-extraction helper
// for the naive_core multi-cycle RV32I CPU.
package naive_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

  // Misaligned word loads return the whole aligned word; sub-word loads take the addressed lane.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_B:    r = {{24{sh[7]}}, sh[7:0]};
      F3_H:    r = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   r = {24'b0, sh[7:0]};
      F3_HU:   r = {16'b0, sh[15:0]};
      F3_W:    r = word;
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/naive_alu.sv
// 32-bit RV32I integer ALU with the branch comparator for naive_core.
module naive_alu
  import naive_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  cmp_f3,
  output logic [31:0] y,
  output logic        taken
);

  logic signed [31:0] sa;
  logic signed [31:0] sb;

  assign sa = a;
  assign sb = b;

  always_comb begin
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, sa < sb};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = sa >>> b[4:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

  always_comb begin
    case (cmp_f3)
      F3_BEQ:  taken = (a == b);
      F3_BNE:  taken = (a != b);
      F3_BLT:  taken = (sa < sb);
      F3_BGE:  taken = (sa >= sb);
      F3_BLTU: taken = (a < b);
      F3_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/naive_core.sv
// Multi-cycle RV32I CPU: fetch over iwb, execute, optional dwb access, write-back.
// One instruction in flight; the two Wishbone masters are never active together.
module naive_core
  import naive_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] io_iwb_addr,
  output logic [31:0] io_iwb_wdata,
  output logic [3:0]  io_iwb_sel,
  output logic        io_iwb_we,
  output logic        io_iwb_cyc,
  output logic        io_iwb_stb,
  input  logic [31:0] io_iwb_rdata,
  input  logic        io_iwb_ack,
  output logic [31:0] io_dwb_addr,
  output logic [31:0] io_dwb_wdata,
  output logic [3:0]  io_dwb_sel,
  output logic        io_dwb_we,
  output logic        io_dwb_cyc,
  output logic        io_dwb_stb,
  input  logic [31:0] io_dwb_rdata,
  input  logic        io_dwb_ack
);

  state_e      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] ea;
  logic [31:0] st_data;
  logic [3:0]  st_sel;
  logic        st_we;
  logic        bus_wait;
  logic [31:0] regs [0:31];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1_v, rs2_v;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4;
  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y;
  logic        br_taken;

  logic        wb_en, to_mem, to_halt;
  logic [31:0] wb_val, next_pc, ea_next, data_next;
  logic [3:0]  sel_next;
  logic        fetch_act, mem_act;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign f3       = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign rs1_v    = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_v    = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u    = {ir[31:12], 12'b0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  // SUB only exists in the register form; in OP-IMM bit 30 belongs to the immediate.
  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
      case (f3)
        F3_ADD:  alu_op = (opcode == OPC_OP && ir[30]) ? ALU_SUB : ALU_ADD;
        F3_SLL:  alu_op = ALU_SLL;
        F3_SLT:  alu_op = ALU_SLT;
        F3_SLTU: alu_op = ALU_SLTU;
        F3_XOR:  alu_op = ALU_XOR;
        F3_SRL:  alu_op = ir[30] ? ALU_SRA : ALU_SRL;
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign alu_b = (opcode == OPC_OP || opcode == OPC_BRANCH) ? rs2_v : imm_i;

  naive_alu u_alu (
    .op     (alu_op),
    .a      (rs1_v),
    .b      (alu_b),
    .cmp_f3 (f3),
    .y      (alu_y),
    .taken  (br_taken)
  );

  always_comb begin
    wb_en   = 1'b0;
    wb_val  = alu_y;
    next_pc = pc_plus4;
    to_mem  = 1'b0;
    to_halt = 1'b0;
    case (opcode)
      OPC_LUI:    begin wb_en = 1'b1; wb_val = imm_u; end
      OPC_AUIPC:  begin wb_en = 1'b1; wb_val = pc + imm_u; end
      OPC_JAL:    begin wb_en = 1'b1; wb_val = pc_plus4; next_pc = pc + imm_j; end
      OPC_JALR:   begin wb_en = 1'b1; wb_val = pc_plus4; next_pc = (rs1_v + imm_i) & ~32'd1; end
      OPC_BRANCH: if (br_taken) next_pc = pc + imm_b;
      OPC_LOAD:   to_mem = 1'b1;
      OPC_STORE:  to_mem = 1'b1;
      OPC_OP:     wb_en = 1'b1;
      OPC_OP_IMM: wb_en = 1'b1;
      OPC_SYSTEM: to_halt = (f3 == 3'b000) && (ir[31:21] == 11'd0) && (rs1 == 5'd0) && (rd == 5'd0);
      OPC_MISC_MEM: wb_en = 1'b0;
      default:    wb_en = 1'b0;
    endcase
  end

  // Store lanes: the 4-bit shift truncates, so SH at offset 3 keeps only lane 3.
  always_comb begin
    ea_next = rs1_v + ((opcode == OPC_STORE) ? imm_s : imm_i);
    case (f3)
      F3_B: begin
        sel_next  = 4'b0001 << ea_next[1:0];
        data_next = {24'b0, rs2_v[7:0]} << {ea_next[1:0], 3'b000};
      end
      F3_H: begin
        sel_next  = 4'b0011 << ea_next[1:0];
        data_next = {16'b0, rs2_v[15:0]} << {ea_next[1:0], 3'b000};
      end
      default: begin
        sel_next  = 4'b1111;
        data_next = rs2_v;
      end
    endcase
  end

  // bus_wait qualifies acks: a slave ack is only taken after the cycle has been
  // presented for a full clock, so an ack left over from an aborted access is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= 32'd0;
      ea       <= 32'd0;
      st_data  <= 32'd0;
      st_sel   <= 4'd0;
      st_we    <= 1'b0;
      bus_wait <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (io_iwb_ack && bus_wait) begin
            ir       <= io_iwb_rdata;
            bus_wait <= 1'b0;
            state    <= S_EXEC;
          end else begin
            bus_wait <= 1'b1;
          end
        end
        S_EXEC: begin
          if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
          if (to_halt) begin
            state <= S_HALT;
          end else if (to_mem) begin
            ea      <= ea_next;
            st_we   <= (opcode == OPC_STORE);
            st_sel  <= (opcode == OPC_STORE) ? sel_next : 4'b1111;
            st_data <= (opcode == OPC_STORE) ? data_next : 32'd0;
            state   <= S_MEM;
          end else begin
            pc    <= next_pc;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (io_dwb_ack && bus_wait) begin
            if (!st_we && rd != 5'd0) regs[rd] <= load_extend(f3, ea[1:0], io_dwb_rdata);
            pc       <= pc_plus4;
            bus_wait <= 1'b0;
            state    <= S_FETCH;
          end else begin
            bus_wait <= 1'b1;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  assign fetch_act = (state == S_FETCH) && !reset;
  assign mem_act   = (state == S_MEM) && !reset;

  assign io_iwb_addr  = pc;
  assign io_iwb_wdata = 32'd0;
  assign io_iwb_sel   = 4'b1111;
  assign io_iwb_we    = 1'b0;
  assign io_iwb_cyc   = fetch_act;
  assign io_iwb_stb   = fetch_act;

  assign io_dwb_addr  = {ea[31:2], 2'b00};
  assign io_dwb_wdata = mem_act ? st_data : 32'd0;
  assign io_dwb_sel   = mem_act ? st_sel : 4'd0;
  assign io_dwb_we    = mem_act && st_we;
  assign io_dwb_cyc   = mem_act;
  assign io_dwb_stb   = mem_act;

endmodule

// File: tb/tb_naive_core.sv
// Directed and randomized bench for naive_core with behavioural Wishbone memories
// and a plain-arithmetic reference for ALU results, load extension and store lanes.
module tb_naive_core;

  localparam logic [6:0]  OPC_LUI = 7'h37, OPC_JAL = 7'h6f, OPC_BR = 7'h63;
  localparam logic [6:0]  OPC_LOAD = 7'h03, OPC_STORE = 7'h23, OPC_OPIMM = 7'h13, OPC_OP = 7'h33;
  localparam logic [31:0] NOP = 32'h0000_0013, ECALL = 32'h0000_0073;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] iwb_addr, iwb_wdata, iwb_rdata, dwb_addr, dwb_wdata, dwb_rdata;
  logic [3:0]  iwb_sel, dwb_sel;
  logic        iwb_we, iwb_cyc, iwb_stb, iwb_ack, dwb_we, dwb_cyc, dwb_stb, dwb_ack;

  naive_core #(.RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .io_iwb_addr(iwb_addr), .io_iwb_wdata(iwb_wdata), .io_iwb_sel(iwb_sel), .io_iwb_we(iwb_we),
    .io_iwb_cyc(iwb_cyc), .io_iwb_stb(iwb_stb), .io_iwb_rdata(iwb_rdata), .io_iwb_ack(iwb_ack),
    .io_dwb_addr(dwb_addr), .io_dwb_wdata(dwb_wdata), .io_dwb_sel(dwb_sel), .io_dwb_we(dwb_we),
    .io_dwb_cyc(dwb_cyc), .io_dwb_stb(dwb_stb), .io_dwb_rdata(dwb_rdata), .io_dwb_ack(dwb_ack)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } st_t;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  st_t         st_q[$];
  logic [31:0] f_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pa = 0;

  // Registered-ack slaves; stores and completed fetches are logged for checking.
  always @(posedge clock) begin
    if (reset) begin
      iwb_ack <= 1'b0;
      dwb_ack <= 1'b0;
    end else begin
      iwb_ack   <= iwb_cyc && iwb_stb && !iwb_ack;
      iwb_rdata <= imem[iwb_addr[9:2]];
      dwb_ack   <= dwb_cyc && dwb_stb && !dwb_ack;
      dwb_rdata <= dmem[dwb_addr[9:2]];
      if (iwb_cyc && iwb_stb && iwb_ack) f_q.push_back(iwb_addr);
      if (dwb_cyc && dwb_stb && dwb_ack && dwb_we) st_q.push_back('{dwb_addr, dwb_sel, dwb_wdata});
    end
  end

  function automatic logic [31:0] i_t(logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                      logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction
  function automatic logic [31:0] s_t(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                      logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] u_t(logic [4:0] rd, logic [19:0] imm);
    return {imm, rd, OPC_LUI};
  endfunction
  function automatic logic [31:0] b_t(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                      logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BR};
  endfunction
  function automatic logic [31:0] j_t(logic [4:0] rd, logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  // Reference results by operation meaning: 0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and.
  function automatic logic [31:0] ref_alu(int k, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (k)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3: return (sa < sb) ? 32'd1 : 32'd0;
      4: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: return 32'(sa >>> sh);
      8: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic emit(input logic [31:0] w);
    imem[pa[9:2]] = w;
    pa += 4;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = ECALL;
    pa = 0;
  endtask

  task automatic li(input logic [4:0] rd, input logic [31:0] v);
    logic [31:0] up;
    up = (v + 32'h800) >> 12;
    emit(u_t(rd, up[19:0]));
    emit(i_t(OPC_OPIMM, rd, 3'd0, rd, v[11:0]));
  endtask

  task automatic run(input int nst, input string tag);
    reset = 1'b1;
    tick(2);
    st_q.delete();
    f_q.delete();
    reset = 1'b0;
    for (int c = 0; c < 400 && st_q.size() < nst; c++) tick(1);
    check({tag, "_done"}, 32'(st_q.size() >= nst), 32'd1);
  endtask

  logic [2:0] f3_of [10];
  logic [6:0] f7_of [10];
  logic [2:0] lf3_tab [5];

  initial begin
    f3_of   = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    f7_of   = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    lf3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 256; i++) begin
      imem[i] = NOP;
      dmem[i] = 32'd0;
    end

    // Reset and first fetch timing
    reset = 1'b1;
    repeat (3) begin
      tick(1);
      check("rst_iwb_cyc", iwb_cyc, 0);
      check("rst_iwb_stb", iwb_stb, 0);
      check("rst_dwb_cyc", dwb_cyc, 0);
    end
    reset = 1'b0;
    #1;
    check("f0_addr", iwb_addr, 32'h0);
    check("f0_cyc", iwb_cyc, 1);
    check("f0_stb", iwb_stb, 1);
    check("f0_sel", iwb_sel, 4'hF);
    check("f0_we", iwb_we, 0);
    tick(2);
    check("exec_gap_cyc", iwb_cyc, 0);
    tick(1);
    check("f1_addr", iwb_addr, 32'h4);
    check("f1_cyc", iwb_cyc, 1);

    // AND datapath
    clear_prog();
    emit(u_t(5'd1, 20'hff010));
    emit(i_t(OPC_OPIMM, 5'd1, 3'd0, 5'd1, 12'hf00));
    emit(u_t(5'd2, 20'h0f0f1));
    emit(i_t(OPC_OPIMM, 5'd2, 3'd0, 5'd2, 12'hf0f));
    emit(r_t(7'h00, 5'd2, 5'd1, 3'd7, 5'd3));
    emit(s_t(3'd2, 5'd0, 5'd3, 12'h100));
    run(1, "and");
    check("and_addr", st_q[0].addr, 32'h100);
    check("and_sel", st_q[0].sel, 4'hF);
    check("and_data", st_q[0].data, 32'h0f000f00);

    // Byte and halfword store lanes
    clear_prog();
    emit(i_t(OPC_OPIMM, 5'd5, 3'd0, 5'd0, 12'h0ab));
    emit(s_t(3'd0, 5'd0, 5'd5, 12'h101));
    emit(s_t(3'd1, 5'd0, 5'd5, 12'h102));
    run(2, "sbsh");
    check("sb_addr", st_q[0].addr, 32'h100);
    check("sb_sel", st_q[0].sel, 4'b0010);
    check("sb_lane", {24'd0, st_q[0].data[15:8]}, 32'hab);
    check("sh_sel", st_q[1].sel, 4'b1100);
    check("sh_lane", {16'd0, st_q[1].data[31:16]}, 32'h00ab);

    // Load extension
    dmem[8'h80] = 32'h0000_8080;
    clear_prog();
    emit(i_t(OPC_LOAD, 5'd6, 3'd0, 5'd0, 12'h200));
    emit(s_t(3'd2, 5'd0, 5'd6, 12'h100));
    emit(i_t(OPC_LOAD, 5'd6, 3'd4, 5'd0, 12'h200));
    emit(s_t(3'd2, 5'd0, 5'd6, 12'h100));
    emit(i_t(OPC_LOAD, 5'd6, 3'd1, 5'd0, 12'h200));
    emit(s_t(3'd2, 5'd0, 5'd6, 12'h100));
    emit(i_t(OPC_LOAD, 5'd6, 3'd5, 5'd0, 12'h200));
    emit(s_t(3'd2, 5'd0, 5'd6, 12'h100));
    run(4, "ldext");
    check("lb", st_q[0].data, 32'hffffff80);
    check("lbu", st_q[1].data, 32'h00000080);
    check("lh", st_q[2].data, 32'hffff8080);
    check("lhu", st_q[3].data, 32'h00008080);

    // Taken branch
    clear_prog();
    repeat (4) emit(NOP);
    emit(b_t(3'd0, 5'd0, 5'd0, 13'd8));
    emit(ECALL);
    emit(s_t(3'd2, 5'd0, 5'd0, 12'h100));
    run(1, "beq");
    check("beq_at", f_q[4], 32'h10);
    check("beq_next", f_q[5], 32'h18);

    // Not-taken branch
    clear_prog();
    repeat (4) emit(NOP);
    emit(b_t(3'd1, 5'd0, 5'd0, 13'd8));
    emit(s_t(3'd2, 5'd0, 5'd0, 12'h104));
    run(1, "bne");
    check("bne_next", f_q[5], 32'h14);

    // JAL link and target
    clear_prog();
    repeat (8) emit(NOP);
    emit(j_t(5'd1, 21'd16));
    pa = 32'h30;
    emit(s_t(3'd2, 5'd0, 5'd1, 12'h100));
    run(1, "jal");
    check("jal_at", f_q[8], 32'h20);
    check("jal_next", f_q[9], 32'h30);
    check("jal_link", st_q[0].data, 32'h24);

    // x0 stays zero, then ECALL halts
    clear_prog();
    emit(i_t(OPC_OPIMM, 5'd0, 3'd0, 5'd0, 12'd5));
    emit(s_t(3'd2, 5'd0, 5'd0, 12'h100));
    emit(ECALL);
    run(1, "x0");
    check("x0_data", st_q[0].data, 32'h0);
    tick(6);
    check("halt_last_fetch", f_q[f_q.size()-1], 32'h8);
    begin
      logic busy;
      busy = 1'b0;
      for (int c = 0; c < 20; c++) begin
        tick(1);
        busy = busy | iwb_cyc | dwb_cyc;
      end
      check("halt_idle", busy, 0);
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    #1;
    check("restart_addr", iwb_addr, 32'h0);
    check("restart_cyc", iwb_cyc, 1);

    // Randomized ALU operations, register and immediate forms
    for (int n = 0; n < 24; n++) begin
      int          k;
      logic [31:0] a, b;
      logic [11:0] imm;
      logic        use_imm;
      k = int'($urandom_range(0, 9));
      a = $urandom;
      b = $urandom;
      use_imm = (k != 1) && ($urandom_range(0, 1) == 1);
      clear_prog();
      li(5'd1, a);
      if (use_imm) begin
        if (k == 2 || k == 6 || k == 7) imm = {(k == 7) ? 7'h20 : 7'h00, b[4:0]};
        else imm = b[11:0];
        b = {{20{imm[11]}}, imm};
        emit(i_t(OPC_OPIMM, 5'd3, f3_of[k], 5'd1, imm));
      end else begin
        li(5'd2, b);
        emit(r_t(f7_of[k], 5'd2, 5'd1, f3_of[k], 5'd3));
      end
      emit(s_t(3'd2, 5'd0, 5'd3, 12'h100));
      run(1, "alu");
      check($sformatf("alu_k%0d_imm%0d", k, use_imm), st_q[0].data, ref_alu(k, a, b));
    end

    // Randomized loads at random lanes
    for (int n = 0; n < 10; n++) begin
      logic [31:0] w, e;
      logic [2:0]  lf;
      logic [7:0]  by [4];
      int          off;
      w  = $urandom;
      lf = lf3_tab[$urandom_range(0, 4)];
      if (lf == 3'd2) off = 0;
      else if (lf == 3'd1 || lf == 3'd5) off = 2 * int'($urandom_range(0, 1));
      else off = int'($urandom_range(0, 3));
      for (int j = 0; j < 4; j++) by[j] = w[8*j +: 8];
      case (lf)
        3'd0:    e = {{24{by[off][7]}}, by[off]};
        3'd4:    e = {24'd0, by[off]};
        3'd1:    e = {{16{by[off+1][7]}}, by[off+1], by[off]};
        3'd5:    e = {16'd0, by[off+1], by[off]};
        default: e = w;
      endcase
      dmem[8'h80] = w;
      clear_prog();
      emit(i_t(OPC_LOAD, 5'd6, lf, 5'd0, 12'(32'h200 + off)));
      emit(s_t(3'd2, 5'd0, 5'd6, 12'h100));
      run(1, "ld");
      check($sformatf("ld_f%0d_o%0d", lf, off), st_q[0].data, e);
    end

    // Randomized stores at random lanes
    for (int n = 0; n < 10; n++) begin
      logic [31:0] v, edata, mask;
      logic [3:0]  esel;
      int          sf, off;
      v  = $urandom;
      sf = int'($urandom_range(0, 2));
      if (sf == 2) off = 0;
      else if (sf == 1) off = int'($urandom_range(0, 2));
      else off = int'($urandom_range(0, 3));
      esel  = 4'd0;
      edata = 32'd0;
      mask  = 32'd0;
      for (int j = 0; j < (1 << sf); j++) begin
        esel[off+j]             = 1'b1;
        edata[8*(off+j) +: 8]   = v[8*j +: 8];
        mask[8*(off+j) +: 8]    = 8'hff;
      end
      clear_prog();
      li(5'd5, v);
      emit(s_t(3'(sf), 5'd0, 5'd5, 12'(32'h300 + off)));
      run(1, "st");
      check($sformatf("st_addr_s%0d", sf), st_q[0].addr, 32'h300);
      check($sformatf("st_sel_s%0d_o%0d", sf, off), st_q[0].sel, esel);
      check($sformatf("st_data_s%0d_o%0d", sf, off), st_q[0].data & mask, edata);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/naive_core.md
Name: naive_core

Overview:
- Non-pipelined, multi-cycle RV32I integer CPU with two Wishbone-classic master ports.
- The iwb port fetches instructions and the dwb port performs loads and stores.
- One instruction is in flight at a time: fetch, execute, optional memory access, write-back.
- Sits at the top of the CPU hierarchy; instruction and data memories are external Wishbone slaves.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- io_iwb_addr  out  32  instruction byte address (PC).
- io_iwb_wdata  out  32  constant 0.
- io_iwb_sel  out  4  constant 4'b1111.
- io_iwb_we  out  1  constant 0.
- io_iwb_cyc  out  1  fetch cycle active.
- io_iwb_stb  out  1  fetch strobe (equal to cyc).
- io_iwb_rdata  in  32  instruction word, little-endian.
- io_iwb_ack  in  1  fetch acknowledge.
- io_dwb_addr  out  32  data address, word-aligned (effective address with bits [1:0] cleared).
- io_dwb_wdata  out  32  store data shifted onto its byte lanes.
- io_dwb_sel  out  4  byte-lane enables.
- io_dwb_we  out  1  1 = store, 0 = load.
- io_dwb_cyc  out  1  data cycle active.
- io_dwb_stb  out  1  data strobe (equal to cyc).
- io_dwb_rdata  in  32  load data.
- io_dwb_ack  in  1  data acknowledge.

Behaviour:
- State machine: FETCH, EXEC, MEM, HALT.
- Reset:
  - pc=RESET_PC, state=FETCH, x1..x31 cleared to 0.
  - All cyc/stb/we=0, dwb_sel=0, dwb_wdata=0.
  - Reset asserted mid-transaction aborts it; any ack arriving later is ignored.
- FETCH:
  - iwb_cyc=stb=1, iwb_addr=pc, held until ack.
  - On an edge with ack=1: latch rdata into the instruction register, drop cyc/stb, go to EXEC.
  - Slave ack is registered, so a fetch takes 2 cycles.
- EXEC (1 cycle):
  - Decode, read rs1/rs2, compute through the ALU.
  - ALU/LUI/AUIPC/JAL/JALR/branch: write rd and update pc, then go to FETCH.
  - Load/store: compute ea=rs1+imm and go to MEM.
- MEM:
  - dwb_cyc=stb=1, addr={ea[31:2],2'b00}, held until ack.
  - Loads: we=0, sel=4'b1111.
  - Stores: we=1, sel = SB 4'b0001<<ea[1:0], SH 4'b0011<<ea[1:0], SW 4'b1111; wdata = rs2 replicated/shifted onto the lanes.
  - On ack, loads extract the lane selected by ea[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. Write rd, pc+=4, go to FETCH.
- Misaligned accesses: no trap. SH at ea[1:0]=3 is masked to lane 3 only; misaligned LW returns the whole aligned word.
- Cycle counts: ALU/branch instruction = 3 cycles; load/store = 5 cycles.
- Instruction set: full RV32I (LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP).
  - Shifts use the low 5 bits of the shift amount; SRA/SRAI are arithmetic.
  - SLT/SLTU are signed/unsigned respectively.
  - JAL/JALR write pc+4 to rd; the JALR target has bit 0 cleared.
  - A taken branch sets pc=pc+imm.
- Register file: x0 reads 0, writes to x0 discarded.
- FENCE, CSR ops and unknown opcodes: executed as NOP (pc+=4).
- ECALL/EBREAK: go to HALT. No further bus cycles are issued; only reset leaves HALT.
- Never assert iwb and dwb cycles simultaneously.

Decomposition:
- Package naive_pkg: opcode localparams (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM), funct3 codes, ALU-op enum, state enum.
- One sub-module, naive_alu: 32-bit add/sub/sll/slt/sltu/xor/srl/sra/or/and plus branch compare.
- Register file and control stay inline.

Test Plan:
- Reset/first fetch:
  - Stimulus: hold reset 3 cycles, then release.
  - Required: during reset iwb_cyc=stb=0 and dwb_cyc=0.
  - Required: on the first cycle after release, iwb_addr=0, cyc=stb=1, sel=4'hF, we=0.
  - Required: the second fetch (after a NOP) has iwb_addr=4, exactly 3 cycles later.
- AND datapath:
  - Program: lui x1,0xff010; addi x1,x1,-256; lui x2,0x0f0f1; addi x2,x2,-241; and x3,x1,x2; sw x3,0x100(x0).
  - Required dwb cycle: addr=0x100, we=1, sel=4'hF, wdata=0x0f000f00.
- Byte store lanes:
  - Program: addi x5,x0,0xab; sb x5,0x101(x0).
  - Required: dwb addr=0x100, sel=4'b0010, wdata bits[15:8]=0xab.
  - Program: sh x5,0x102(x0).
  - Required: sel=4'b1100, wdata[31:16]=0x00ab.
- Load extension:
  - Setup: data word at 0x200 = 0x00008080.
  - lb x6,0x200(x0) → sw x6 emits 0xffffff80.
  - lbu → 0x00000080.
  - lh → 0xffff8080.
  - lhu → 0x00008080.
- Control flow:
  - Taken beq x0,x0,+8 at pc=0x10: next iwb_addr=0x18.
  - Not-taken bne x0,x0: next iwb_addr=0x14.
  - jal x1,+16 at 0x20: next fetch 0x30, and x1=0x24 (checked via sw).
- x0 and halt:
  - addi x0,x0,5; sw x0,0x100 → wdata=0.
  - ecall → no iwb/dwb cyc asserted for 20 cycles.
  - Pulse reset → fetching restarts at 0.
